// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory responder.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port storage: synchronous write, combinational read, no reset.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: one request at a time, programmable wait states.
// Define MIPS_MEM_MISALIGN_ERR_EN to flag req_addr[1:0] != 0 as an error.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_W'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              req_err;
  logic              commit;
  logic              cur_we, cur_err;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;

`ifdef MIPS_MEM_MISALIGN_ERR_EN
  assign req_err = (|req_addr[WORD_W-1:AW+2]) | (|req_addr[1:0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_err = |req_addr[WORD_W-1:AW+2];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - WAIT_W'(1);
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the accept edge, so use the live request.
  always_comb begin
    cur_we    = we_q;
    cur_err   = err_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_err   = req_err;
      cur_idx   = req_addr[AW+1:2];
      cur_wdata = req_wdata;
    end
  end

  assign commit = (state_d == RESP) && (state_q != RESP);
  assign arr_we = commit && cur_we && !cur_err;

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_err_q <= cur_err;
        if (cur_err)     rdata_q <= '0;
        else if (!cur_we) rdata_q <= arr_rdata;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: three instances with WAIT_STATES 1, 0 and 3.
module tb_mips_mem_responder;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_we = '0;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_rdata [3];

  int          ws [3] = '{1, 0, 3};
  logic [31:0] mdl [3][256];
  logic [31:0] last_rd [3];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  mips_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  mips_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int idx, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic mis;
    mis = 1'b0;
`ifdef MIPS_MEM_MISALIGN_ERR_EN
    mis = |addr[1:0];
`endif
    e.idx = idx;
    e.err = (|addr[31:10]) | mis;
    e.lat = ws[idx] + 1;
    if (e.err) begin
      e.rdata = '0;
    end else if (we) begin
      e.rdata = last_rd[idx];
      mdl[idx][addr[9:2]] = wdata;
    end else begin
      e.rdata = mdl[idx][addr[9:2]];
    end
    last_rd[idx] = e.rdata;
    return e;
  endfunction

  // Present a request until the accept edge, then scramble the inputs to prove they were captured.
  task automatic accept_req(input int idx, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    req_we[idx]    = ~we;
    req_addr[idx]  = ~addr;
    req_wdata[idx] = ~wdata;
  endtask

  task automatic do_req(input int idx, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   got;
    sb.push_back(model(idx, we, addr, wdata));
    accept_req(idx, we, addr, wdata);
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin
        got = 1'b1;
        e = sb.pop_front();
        chk("latency", k, e.lat);
        chk("rsp_err", {31'b0, rsp_err[e.idx]}, {31'b0, e.err});
        chk("rsp_rdata", rsp_rdata[e.idx], e.rdata);
        chk("ready_in_resp", {31'b0, req_ready[idx]}, 32'd0);
      end else begin
        chk("ready_while_busy", {31'b0, req_ready[idx]}, 32'd0);
      end
    end
    if (!got) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("single_pulse", {31'b0, rsp_valid[idx]}, 32'd0);
    chk("ready_after", {31'b0, req_ready[idx]}, 32'd1);
    chk("rdata_held", rsp_rdata[idx], last_rd[idx]);
  endtask

  task automatic chk_idle_outputs(input int idx);
    chk("rst_ready", {31'b0, req_ready[idx]}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid[idx]}, 32'd0);
    chk("rst_rdata", rsp_rdata[idx], 32'd0);
    chk("rst_err",   {31'b0, rsp_err[idx]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      last_rd[i]   = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs(0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_outputs(i);

    do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h0000_0010, 32'h0);

    do_req(1, 1'b1, 32'h0000_0040, 32'h0102_0304);
    do_req(1, 1'b0, 32'h0000_0040, 32'h0);
    do_req(2, 1'b1, 32'h0000_0040, 32'h55AA_55AA);
    do_req(2, 1'b0, 32'h0000_0040, 32'h0);

    do_req(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
    do_req(0, 1'b1, 32'h0000_0400, 32'h1234_5678);
    do_req(0, 1'b0, 32'h0000_0000, 32'h0);
    do_req(0, 1'b0, 32'h0000_0400, 32'h0);
    do_req(0, 1'b0, 32'h8000_03FC, 32'h0);
    do_req(0, 1'b0, 32'h0000_03FC, 32'h0);

    do_req(0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    do_req(0, 1'b0, 32'h0000_0013, 32'h0);
    do_req(1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    do_req(1, 1'b0, 32'h0000_0013, 32'h0);

    do_req(2, 1'b1, 32'h0000_0020, 32'h1111_2222);
    accept_req(2, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_valid", {31'b0, rsp_valid[2]}, 32'd0);
      chk("midrst_rdata", rsp_rdata[2], 32'd0);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, rsp_valid[2]}, 32'd0);
    end
    chk_idle_outputs(2);
    do_req(2, 1'b0, 32'h0000_0020, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's unified instruction/data memory port.
- Accepts one fetch, load or store request at a time through a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a one-cycle response pulse carrying read data and an error flag.
- Sits between the core's address mux (PC or ALUOut) and the word-addressed storage array.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; must be a power of 2 and at least 2.
- WAIT_STATES, 1: extra cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = read (fetch or load).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read data; held until the next response.
- rsp_err  out  1  request was out of range (or misaligned, see Optional Feature); valid with rsp_valid.

Behaviour:
- Reset: reset low forces state IDLE and wait counter 0. Outputs during and after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset does not clear the storage array.
- Reset asserted mid-transaction drops the captured request. No write is committed unless the commit edge has already occurred.
- Word index is req_addr[log2(DEPTH)+1:2]. Out of range means any bit of req_addr[31:log2(DEPTH)+2] is set.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - Accept happens on a rising edge with req_valid=1.
  - On accept, capture we, addr and wdata into internal registers; later changes on the req_* inputs are ignored.
  - If WAIT_STATES=0, go to RESP. Otherwise go to ACCESS with counter=WAIT_STATES-1.
- ACCESS:
  - req_ready=0.
  - Counter decrements each cycle. When counter=0, go to RESP.
- Commit edge (the edge entering RESP):
  - Store in range: array[index] <= wdata.
  - Read in range: rsp_rdata <= array[index].
  - Any out-of-range request: rsp_rdata <= 0, no write.
  - rsp_err is registered on the same edge.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0.
  - Next state is always IDLE.
  - Responses have no backpressure.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+1, where N is the accepting cycle. A new accept is possible in cycle N+WAIT_STATES+2.
- Store responses:
  - rsp_valid still pulses.
  - rsp_rdata keeps the old value for a store.
- Ordering: a read following a store to the same word returns the stored value. There is no bypass hazard because requests are serialized.
- req_valid in ACCESS or RESP is ignored; the requester must hold it until req_ready is seen.
- Wait counter width: 4 bits. Width arithmetic is unsigned, with no wrap: the counter never decrements below 0.

Optional Feature:
- Macro: MIPS_MEM_MISALIGN_ERR_EN.
- Defined: req_addr[1:0] != 0 is treated as an error. The response has rsp_err=1, rsp_rdata=0, and no write is performed. Error conditions combine with OR.
- Undefined: req_addr[1:0] is ignored, and misaligned requests act on the containing word.

Decomposition:
- Package mips_mem_pkg holds:
  - WORD_W=32.
  - The state enum (IDLE, ACCESS, RESP) as a 2-bit logic type.
  - Helper constant WAIT_W=4.
- Sub-module mem_array: single-port synchronous-write RAM with parameter DEPTH.
  - Inputs: we, word address, wdata.
  - Read: combinational read of the addressed word, registered by the responder at the commit edge.
  - No reset on the array.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store then read, WAIT_STATES=1:
  - Store addr 0x10, wdata 0xDEADBEEF accepted in cycle N → rsp_valid in N+2 with rsp_err=0.
  - Read 0x10 → rsp_rdata=0xDEADBEEF in the response cycle.
- Latency sweep WAIT_STATES=0 and 3: read accepted in cycle N → rsp_valid only in N+1 and N+4 respectively; req_ready=0 from N+1 through the response cycle.
- Out of range, DEPTH=256:
  - Store 0x400 with 0x12345678 → rsp_err=1.
  - Read 0x000 → its earlier content is unchanged.
  - Read 0x400 → rsp_rdata=0, rsp_err=1.
- Reset mid-op:
  - Store 0x20, 0xA5A5A5A5 with WAIT_STATES=3; assert reset one cycle after accept → no rsp_valid.
  - Read 0x20 after release → prior value, not 0xA5A5A5A5.
- Misaligned read 0x13, with a known word 0xCAFEF00D at 0x10:
  - With MIPS_MEM_MISALIGN_ERR_EN: rsp_err=1, rsp_rdata=0.
  - Without it: rsp_err=0, rsp_rdata=0xCAFEF00D.
